rca_seq_ctrl: RTL

RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

---
 rtl/rca_seq_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: sequential W = N*K bit adder built around one N-bit ripple-carry slice.
// The slice processes one chunk per RUN cycle, starting with the least significant chunk.
// Operands are latched when in_valid && in_ready.
// The result is held in DONE until out_ready is seen.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready is high only in IDLE
//   a, b, cin             W-bit operands and carry-in
//   out_valid / out_ready result handshake; out_valid is high only in DONE
//   sum, cout             registered W-bit sum and carry-out
//   cycles                number of RUN cycles spent on the current result
//
// Build option:
//   RCA_SEQ_EARLY_EXIT_EN  RUN ends early once the remaining operand chunks and the
//                          carry are all zero.
module rca_seq_ctrl #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*K-1:0]           a,
    input  logic [N*K-1:0]           b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*K-1:0]           sum,
    output logic                     cout,
    output logic [$clog2(K+1)-1:0]   cycles
);

    localparam int W  = N * K;
    localparam int CW = $clog2(K + 1);
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            carry_q, carry_d, cout_q, cout_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cycles_q, cycles_d;

    logic            accept;
    logic            last_chunk;
    logic            zero_exit;
    logic [N-1:0]    a_chunk, b_chunk, slice_sum;
    logic [N:0]      rc;

    assign accept     = in_valid && in_ready;
    assign last_chunk = (idx_q == IW'(K - 1));

    // The single time-shared N-bit ripple-carry slice.
    always_comb begin
        a_chunk   = a_q[idx_q*N +: N];
        b_chunk   = b_q[idx_q*N +: N];
        slice_sum = '0;
        rc        = '0;
        rc[0]     = carry_q;
        for (int unsigned i = 0; i < N; i++) begin
            slice_sum[i] = a_chunk[i] ^ b_chunk[i] ^ rc[i];
            rc[i+1]      = (a_chunk[i] & b_chunk[i]) | (rc[i] & (a_chunk[i] ^ b_chunk[i]));
        end
    end

`ifdef RCA_SEQ_EARLY_EXIT_EN
    // Remaining chunks idx..K-1 of both operands and the carry are all zero.
    // The rest of sum is therefore already correct, because it was cleared on accept.
    always_comb begin
        zero_exit = (((a_q | b_q) >> (idx_q * N)) == '0) && !carry_q;
    end
`else
    always_comb begin
        zero_exit = 1'b0;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (zero_exit || last_chunk) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state logic
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        idx_d    = idx_q;
        cycles_d = cycles_q;
        if (accept) begin
            a_d      = a;
            b_d      = b;
            carry_d  = cin;
            idx_d    = '0;
            sum_d    = '0;
            cout_d   = 1'b0;
            cycles_d = '0;
        end else if (state_q == RUN) begin
            cycles_d = cycles_q + 1'b1;
            if (!zero_exit) begin
                sum_d[idx_q*N +: N] = slice_sum;
                carry_d             = rc[N];
                if (last_chunk) cout_d = rc[N];
                // idx stays at K-1 so that the slice select stays in range.
                else            idx_d  = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            idx_q    <= '0;
            cycles_q <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            idx_q    <= idx_d;
            cycles_q <= cycles_d;
        end
    end

    // Output logic.
    // Gating in_ready with rst_n keeps it low for the whole time reset is asserted.
    always_comb begin
        in_ready  = rst_n && (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        cout      = cout_q;
        cycles    = cycles_q;
    end

endmodule
